// File: rtl/dac_output_spi_hpf_param.sv
// DAC output stage: offset-binary sample -> reference subtract -> high-pass -> dead-band -> gain,
// then serialised as a SYNC/SCLK/DIN frame ({CMD_BITS, code}) to an AD5662-style DAC.
//
// state | meaning
// IDLE  | in_ready high, waiting for a sample
// LOAD  | datapath evaluated, filter state / code / threshold registered, frame loaded
// SETUP | SYNC low, SCLK low, first bit on DIN
// SHIFT | one bit per SCLK period (high phase, then low phase; bit advances on the fall)
// HOLD  | SYNC high before returning to IDLE
module dac_output_spi_hpf_param #(
  parameter int DATA_W   = 16,
  parameter int CMD_W    = 8,
  parameter int CLK_DIV  = 2,
  parameter int CMD_BITS = 0
) (
  input  logic              dataclk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       DAC_input,
  input  logic              software_reference_mode,
  input  logic [15:0]       software_reference,
  input  logic              HPF_en,
  input  logic [15:0]       HPF_coefficient,
  input  logic [2:0]        gain,
  input  logic [6:0]        noise_suppress,
  input  logic              DAC_en,
  input  logic [15:0]       DAC_thrsh,
  input  logic              DAC_thrsh_pol,
  output logic              DAC_SYNC,
  output logic              DAC_SCLK,
  output logic              DAC_DIN,
  output logic [DATA_W-1:0] DAC_register,
  output logic              DAC_thrsh_out,
  output logic              frame_done
);

  localparam int FRAME_W = CMD_W + DATA_W;
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [4:0] BITS_M1 = 5'(FRAME_W - 1);
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t r_state, w_next;

  logic [15:0]        r_sample;
  logic [31:0]        r_hpf_state;
  logic [FRAME_W-1:0] r_frame;
  logic [7:0]         r_cnt;
  logic [4:0]         r_bits;
  logic               r_hi;
  logic               r_sync, r_sclk, r_din, r_frame_done, r_thr;
  logic [DATA_W-1:0]  r_dac_reg;

  logic [15:0]        w_x, w_ref, w_xr, w_f, w_db, w_g, w_code16, w_y;
  logic [16:0]        w_diff, w_t;
  logic [17:0]        w_x18, w_hs;
  logic [18:0]        w_d19;
  logic signed [17:0] w_d, w_coef;
  logic signed [35:0] w_p;
  logic [10:0]        w_ns;
  logic [23:0]        w_g24;
  logic [DATA_W-1:0]  w_code;
  logic               w_thr;
  logic               w_unused;

  assign w_coef = {1'b0, HPF_coefficient, 1'b0};
  assign w_p    = w_d * w_coef;

  always_comb begin
    w_x    = {~r_sample[15], r_sample[14:0]};
    w_ref  = {~software_reference[15], software_reference[14:0]};
    w_diff = {w_x[15], w_x} - {w_ref[15], w_ref};
    w_xr   = w_x;
    if (software_reference_mode) begin
      if (w_diff[16] != w_diff[15]) w_xr = w_diff[16] ? 16'h8000 : 16'h7FFF;
      else                          w_xr = w_diff[15:0];
    end
    w_x18 = {w_xr, 2'b00};
    w_hs  = r_hpf_state[31:14];
    w_d19 = {w_x18[17], w_x18} - {w_hs[17], w_hs};
    if (w_d19[18] != w_d19[17]) w_d = w_d19[18] ? 18'sh20000 : 18'sh1FFFF;
    else                        w_d = w_d19[17:0];
    w_f  = HPF_en ? w_d[17:2] : w_xr;
    w_ns = {noise_suppress, 4'b0000};
    // dead-band pulls toward zero; a sign flip means the value was inside the band
    if (!w_f[15]) begin
      w_t  = {1'b0, w_f} - {6'd0, w_ns};
      w_db = w_t[16] ? 16'h0000 : w_t[15:0];
    end else begin
      w_t  = {1'b1, w_f} + {6'd0, w_ns};
      w_db = w_t[16] ? w_t[15:0] : 16'h0000;
    end
    w_g24 = {{8{w_db[15]}}, w_db} << gain;
    if ((&w_g24[23:15]) || !(|w_g24[23:15])) w_g = w_g24[15:0];
    else                                     w_g = w_db[15] ? 16'h8000 : 16'h7FFF;
    w_code16 = {~w_g[15], w_g[14:0]};
    w_code   = DAC_en ? w_code16[15 -: DATA_W] : MIDSCALE;
    w_y      = {~w_f[15], w_f[14:0]};
    w_thr    = DAC_en & (DAC_thrsh_pol ? (w_y >= DAC_thrsh) : (w_y <= DAC_thrsh));
  end

  assign w_unused = &{1'b0, w_p[35], w_p[2:0], w_code16};

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_LOAD;
      S_LOAD:  w_next = S_SETUP;
      S_SETUP: if (r_cnt == 8'd0) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == 8'd0 && !r_hi && r_bits == 5'd0) w_next = S_HOLD;
      S_HOLD:  if (r_cnt == 8'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // SPI pins are registered from the current state, so they trail the FSM by one cycle
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample     <= 16'h0000;
      r_hpf_state  <= 32'h0000_0000;
      r_frame      <= '0;
      r_cnt        <= 8'd0;
      r_bits       <= 5'd0;
      r_hi         <= 1'b0;
      r_sync       <= 1'b1;
      r_sclk       <= 1'b0;
      r_din        <= 1'b0;
      r_frame_done <= 1'b0;
      r_thr        <= 1'b0;
      r_dac_reg    <= MIDSCALE;
    end else begin
      r_sync       <= !(r_state == S_SETUP || r_state == S_SHIFT);
      r_sclk       <= (r_state == S_SHIFT) && r_hi;
      r_din        <= (r_state == S_SETUP || r_state == S_SHIFT) && r_frame[FRAME_W-1];
      r_frame_done <= (r_state == S_HOLD) && !r_sync;
      case (r_state)
        S_IDLE: if (in_valid) r_sample <= DAC_input;
        S_LOAD: begin
          r_cnt     <= DIV_M1;
          r_frame   <= (FRAME_W'(CMD_BITS) << DATA_W) | FRAME_W'(w_code);
          r_dac_reg <= w_code;
          r_thr     <= w_thr;
          if (HPF_en) r_hpf_state <= r_hpf_state + w_p[34:3];
        end
        S_SETUP: begin
          if (r_cnt == 8'd0) begin
            r_cnt  <= DIV_M1;
            r_hi   <= 1'b1;
            r_bits <= BITS_M1;
          end else r_cnt <= r_cnt - 8'd1;
        end
        S_SHIFT: begin
          if (r_cnt == 8'd0) begin
            r_cnt <= DIV_M1;
            if (r_hi) begin
              r_hi    <= 1'b0;
              r_frame <= r_frame << 1;
            end else if (r_bits != 5'd0) begin
              r_hi   <= 1'b1;
              r_bits <= r_bits - 5'd1;
            end
          end else r_cnt <= r_cnt - 8'd1;
        end
        S_HOLD: if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        default: r_cnt <= 8'd0;
      endcase
    end
  end

  assign in_ready      = (r_state == S_IDLE);
  assign DAC_SYNC      = r_sync;
  assign DAC_SCLK      = r_sclk;
  assign DAC_DIN       = r_din;
  assign DAC_register  = r_dac_reg;
  assign DAC_thrsh_out = r_thr;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_dac_output_spi_hpf_param.sv
// Bench for dac_output_spi_hpf_param: vector table plus scoreboard on the serial frame,
// with hand sequences for back-to-back valid, reset abort, HPF decay and a 12-bit instance.
module tb_dac_output_spi_hpf_param;

  logic        dataclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_valid2 = 1'b0;
  logic        in_ready, in_ready2;
  logic [15:0] DAC_input = 16'h0;
  logic        software_reference_mode = 1'b0;
  logic [15:0] software_reference = 16'h0;
  logic        HPF_en = 1'b0;
  logic [15:0] HPF_coefficient = 16'h0;
  logic [2:0]  gain = 3'd0;
  logic [6:0]  noise_suppress = 7'd0;
  logic        DAC_en = 1'b1, DAC_en2 = 1'b0;
  logic [15:0] DAC_thrsh = 16'h0;
  logic        DAC_thrsh_pol = 1'b0;
  logic        DAC_SYNC, DAC_SCLK, DAC_DIN, DAC_thrsh_out, frame_done;
  logic [15:0] DAC_register;
  logic        sync2, sclk2, din2, thr2, fd2;
  logic [11:0] dreg2;

  always #5 dataclk = ~dataclk;

  dac_output_spi_hpf_param dut (
    .dataclk(dataclk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .DAC_input(DAC_input), .software_reference_mode(software_reference_mode),
    .software_reference(software_reference), .HPF_en(HPF_en), .HPF_coefficient(HPF_coefficient),
    .gain(gain), .noise_suppress(noise_suppress), .DAC_en(DAC_en), .DAC_thrsh(DAC_thrsh),
    .DAC_thrsh_pol(DAC_thrsh_pol), .DAC_SYNC(DAC_SYNC), .DAC_SCLK(DAC_SCLK), .DAC_DIN(DAC_DIN),
    .DAC_register(DAC_register), .DAC_thrsh_out(DAC_thrsh_out), .frame_done(frame_done)
  );

  dac_output_spi_hpf_param #(.DATA_W(12), .CMD_W(0), .CLK_DIV(1)) dut2 (
    .dataclk(dataclk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .DAC_input(DAC_input), .software_reference_mode(software_reference_mode),
    .software_reference(software_reference), .HPF_en(HPF_en), .HPF_coefficient(HPF_coefficient),
    .gain(gain), .noise_suppress(noise_suppress), .DAC_en(DAC_en2), .DAC_thrsh(DAC_thrsh),
    .DAC_thrsh_pol(DAC_thrsh_pol), .DAC_SYNC(sync2), .DAC_SCLK(sclk2), .DAC_DIN(din2),
    .DAC_register(dreg2), .DAC_thrsh_out(thr2), .frame_done(fd2)
  );

  typedef struct {
    logic [15:0] din;
    logic [2:0]  gain;
    logic [6:0]  ns;
    logic        en;
    logic        rm;
    logic [15:0] rf;
    logic [15:0] th;
    logic        pol;
    logic [15:0] code;
    logic        thr;
  } vec_t;

  typedef struct {
    logic [23:0] frame;
    logic [15:0] dreg;
    logic        thr;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t exp_cur;
  logic [23:0] mon_bits = '0;
  int   mon_cnt = 0;
  logic prev_sclk = 1'b0;
  int   hs_cnt = 0;
  int   ready_viol = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: push on handshake, decode SPI bits on SCLK rise, pop and compare on frame_done
  always @(negedge dataclk) begin
    if (!reset_n) begin
      mon_bits = '0;
      mon_cnt  = 0;
      sb_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        sb_q.push_back(exp_cur);
        hs_cnt++;
      end
      if (!DAC_SYNC && in_ready) ready_viol++;
      if (DAC_SCLK && !prev_sclk && !DAC_SYNC) begin
        mon_bits = {mon_bits[22:0], DAC_DIN};
        mon_cnt++;
      end
      if (frame_done) begin
        if (sb_q.size() == 0) chk("sb_unexpected_frame", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("frame_bits", mon_bits, e.frame);
          chk("frame_len", mon_cnt, 24);
          chk("dac_register", DAC_register, e.dreg);
          chk("thrsh_out", DAC_thrsh_out, e.thr);
        end
        mon_bits = '0;
        mon_cnt  = 0;
      end
    end
    prev_sclk = DAC_SCLK;
  end

  task automatic send(input logic [15:0] din, output int l_sync, output int l_fd, output int l_rdy);
    l_sync = -1; l_fd = -1; l_rdy = -1;
    @(posedge dataclk); #1;
    DAC_input = din;
    in_valid  = 1'b1;
    @(posedge dataclk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge dataclk); #1;
      if (!DAC_SYNC && l_sync < 0) l_sync = n;
      if (frame_done && l_fd < 0) l_fd = n;
      if (in_ready) begin
        l_rdy = n;
        break;
      end
    end
  endtask

  task automatic set_exp(input logic [15:0] code, input logic thr);
    exp_cur.frame = {8'h00, code};
    exp_cur.dreg  = code;
    exp_cur.thr   = thr;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[16];
    int   ls, lf, lr, hs0, nf, st, x18, hs, d, f, n_rdy, cnt2;
    longint p;
    logic [15:0] prev_reg, code;
    logic [11:0] bits2;
    logic        prev2;

    vt[0]  = '{16'h1234, 3'd0, 7'd0,   1'b1, 1'b0, 16'h0000, 16'h1000, 1'b1, 16'h1234, 1'b1};
    vt[1]  = '{16'hC000, 3'd2, 7'd0,   1'b1, 1'b0, 16'h0000, 16'hC000, 1'b0, 16'hFFFF, 1'b1};
    vt[2]  = '{16'h3000, 3'd2, 7'd0,   1'b1, 1'b0, 16'h0000, 16'h2FFF, 1'b0, 16'h0000, 1'b0};
    vt[3]  = '{16'h800F, 3'd0, 7'd1,   1'b1, 1'b0, 16'h0000, 16'h800F, 1'b1, 16'h8000, 1'b1};
    vt[4]  = '{16'h8020, 3'd0, 7'd1,   1'b1, 1'b0, 16'h0000, 16'h8021, 1'b1, 16'h8010, 1'b0};
    vt[5]  = '{16'h7FF0, 3'd0, 7'd1,   1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h8000, 1'b1};
    vt[6]  = '{16'h7FE0, 3'd0, 7'd1,   1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 16'h7FF0, 1'b1};
    vt[7]  = '{16'hABCD, 3'd0, 7'd0,   1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h8000, 1'b0};
    vt[8]  = '{16'hA000, 3'd1, 7'd0,   1'b1, 1'b0, 16'h0000, 16'hA000, 1'b1, 16'hC000, 1'b1};
    vt[9]  = '{16'hC000, 3'd1, 7'd0,   1'b1, 1'b0, 16'h0000, 16'hC001, 1'b1, 16'hFFFF, 1'b0};
    vt[10] = '{16'h4000, 3'd1, 7'd0,   1'b1, 1'b0, 16'h0000, 16'h3FFF, 1'b0, 16'h0000, 1'b0};
    vt[11] = '{16'hA000, 3'd0, 7'd0,   1'b1, 1'b1, 16'h9000, 16'h9000, 1'b0, 16'h9000, 1'b1};
    vt[12] = '{16'hFFFF, 3'd0, 7'd0,   1'b1, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vt[13] = '{16'h0000, 3'd0, 7'd0,   1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1};
    vt[14] = '{16'h8001, 3'd7, 7'd0,   1'b1, 1'b0, 16'h0000, 16'h8002, 1'b0, 16'h8080, 1'b1};
    vt[15] = '{16'h9000, 3'd0, 7'd127, 1'b1, 1'b0, 16'h0000, 16'h9001, 1'b1, 16'h8810, 1'b0};

    // reset state
    #23;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sync", DAC_SYNC, 1);
    chk("rst_sclk", DAC_SCLK, 0);
    chk("rst_din", DAC_DIN, 0);
    chk("rst_dac_register", DAC_register, 16'h8000);
    chk("rst_thrsh_out", DAC_thrsh_out, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_hpf_state", dut.r_hpf_state, 0);
    @(posedge dataclk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      gain = vt[i].gain; noise_suppress = vt[i].ns; DAC_en = vt[i].en;
      software_reference_mode = vt[i].rm; software_reference = vt[i].rf;
      DAC_thrsh = vt[i].th; DAC_thrsh_pol = vt[i].pol;
      set_exp(vt[i].code, vt[i].thr);
      send(vt[i].din, ls, lf, lr);
      chk("lat_sync_fall", ls, 2);
      chk("lat_frame_done", lf, 100);
      chk("lat_ready", lr, 101);
    end

    // in_valid held high: one capture per frame
    gain = 3'd0; noise_suppress = 7'd0; DAC_en = 1'b1; software_reference_mode = 1'b0;
    DAC_thrsh = 16'h0000; DAC_thrsh_pol = 1'b1;
    set_exp(16'h1234, 1'b1);
    hs0 = hs_cnt; nf = 0;
    @(posedge dataclk); #1;
    DAC_input = 16'h1234;
    in_valid = 1'b1;
    for (int n = 0; n < 1000 && nf < 3; n++) begin
      @(negedge dataclk);
      if (frame_done) nf++;
    end
    in_valid = 1'b0;
    chk("hold_valid_frames", nf, 3);
    chk("hold_valid_captures", hs_cnt - hs0, 3);
    repeat (4) @(posedge dataclk);

    // 12-bit, no command, CLK_DIV=1, DAC disabled
    bits2 = '0; cnt2 = 0; prev2 = 1'b0; n_rdy = -1;
    @(posedge dataclk); #1;
    in_valid2 = 1'b1;
    @(posedge dataclk); #1;
    in_valid2 = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge dataclk); #1;
      if (sclk2 && !prev2 && !sync2) begin
        bits2 = {bits2[10:0], din2};
        cnt2++;
      end
      prev2 = sclk2;
      if (in_ready2) begin
        n_rdy = n;
        break;
      end
    end
    chk("w12_bits", bits2, 12'h800);
    chk("w12_len", cnt2, 12);
    chk("w12_load_plus_frame", n_rdy, 27);
    chk("w12_dac_register", dreg2, 12'h800);
    chk("w12_thrsh_out", thr2, 0);

    // HPF decay toward midscale against an arithmetic model
    HPF_en = 1'b1; HPF_coefficient = 16'h4000;
    st = 0; prev_reg = 16'hFFFF;
    for (int k = 0; k < 6; k++) begin
      x18 = (32'h9000 - 32768) * 4;
      hs  = st >>> 14;
      d   = x18 - hs;
      if (d > 131071) d = 131071;
      if (d < -131072) d = -131072;
      p   = longint'(d) * longint'(32'h4000 * 2);
      st  = st + int'(p >>> 3);
      f   = d >>> 2;
      code = 16'(f + 32768);
      set_exp(code, 1'b1);
      send(16'h9000, ls, lf, lr);
      chk("hpf_state", dut.r_hpf_state, st);
      if (k == 0) chk("hpf_first_code", DAC_register, 16'h9000);
      else chk("hpf_monotonic", (DAC_register < prev_reg) && (DAC_register >= 16'h8000), 1);
      prev_reg = DAC_register;
    end

    // reset pulsed mid-SHIFT aborts the frame and clears the filter
    @(posedge dataclk); #1;
    in_valid = 1'b1;
    @(posedge dataclk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge dataclk);
    #1;
    chk("abort_pre_sync_low", DAC_SYNC, 0);
    reset_n = 1'b0;
    #2;
    chk("abort_sync", DAC_SYNC, 1);
    chk("abort_sclk", DAC_SCLK, 0);
    chk("abort_hpf_state", dut.r_hpf_state, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_dac_register", DAC_register, 16'h8000);
    repeat (3) @(posedge dataclk);
    #1;
    reset_n = 1'b1;
    set_exp(16'h9000, 1'b1);
    send(16'h9000, ls, lf, lr);
    chk("post_reset_first_code", DAC_register, 16'h9000);
    chk("post_reset_hpf_state", dut.r_hpf_state, 32'h0400_0000);

    repeat (4) @(posedge dataclk);
    chk("sb_drained", sb_q.size(), 0);
    chk("ready_low_in_frame", ready_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
